// File: rtl/mem_access_if.sv
// Bundle of the pipeline request, memory transaction and response signals
// seen by the M-stage memory access unit.
interface mem_access_if;
    // Pipeline request
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // Memory transaction
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    // Response to the pipeline
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic        stall;

    // The access unit itself
    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output mem_en, mem_we, mem_addr, mem_byteen, mem_wdata,
        input  mem_ack, mem_rdata,
        output resp_valid, resp_rdata, resp_exc, stall
    );

    // The pipeline and the data memory around it
    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  mem_en, mem_we, mem_addr, mem_byteen, mem_wdata,
        output mem_ack, mem_rdata,
        input  resp_valid, resp_rdata, resp_exc, stall
    );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage data memory initiator: checks alignment/range of one load or store,
// issues a word-aligned transaction with lane enables and replicated store data,
// waits (bounded) for mem_ack and returns extended load data or an exception.
module mem_access_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000,
    parameter int          TIMEOUT    = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_if.master bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    state_t      state, stateNext;
    logic        memEn, memEnNext;
    logic        memWe, memWeNext;
    logic [31:0] memAddr, memAddrNext;
    logic [3:0]  memByteen, memByteenNext;
    logic [31:0] memWdata, memWdataNext;
    logic        respValid, respValidNext;
    logic [31:0] respRdata, respRdataNext;
    logic [1:0]  respExc, respExcNext;
    logic [15:0] waitCnt, waitCntNext;
    logic [1:0]  opSize, opSizeNext;
    logic        opUnsigned, opUnsignedNext;
    logic [1:0]  opOff, opOffNext;

    function automatic logic isIllegal(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'b11) ||
               (size == 2'b01 && addr[0]) ||
               (size == 2'b00 && addr[1:0] != 2'b00) ||
               (addr >= ADDR_LIMIT);
    endfunction

    function automatic logic [3:0] laneEnables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b10:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b10:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] extendLoad(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            2'b10: begin
                s = b;
                return uns ? {24'b0, b} : s;
            end
            2'b01: begin
                s = h;
                return uns ? {16'b0, h} : s;
            end
            default: return rdata;
        endcase
    endfunction

    // State register and registered outputs; everything visible on the bus resets.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            memEn     <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= 32'b0;
            memByteen <= 4'b0;
            memWdata  <= 32'b0;
            respValid <= 1'b0;
            respRdata <= 32'b0;
            respExc   <= 2'b00;
        end else begin
            state     <= stateNext;
            memEn     <= memEnNext;
            memWe     <= memWeNext;
            memAddr   <= memAddrNext;
            memByteen <= memByteenNext;
            memWdata  <= memWdataNext;
            respValid <= respValidNext;
            respRdata <= respRdataNext;
            respExc   <= respExcNext;
        end
    end

    // Latched request details and wait counter; always rewritten before use.
    always_ff @(posedge clk) begin
        waitCnt    <= waitCntNext;
        opSize     <= opSizeNext;
        opUnsigned <= opUnsignedNext;
        opOff      <= opOffNext;
    end

    // Next-state and next-output logic for IDLE -> ACCESS -> RESP.
    always_comb begin
        stateNext      = state;
        memEnNext      = memEn;
        memWeNext      = memWe;
        memAddrNext    = memAddr;
        memByteenNext  = memByteen;
        memWdataNext   = memWdata;
        respValidNext  = 1'b0;
        respRdataNext  = respRdata;
        respExcNext    = respExc;
        waitCntNext    = waitCnt;
        opSizeNext     = opSize;
        opUnsignedNext = opUnsigned;
        opOffNext      = opOff;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (isIllegal(bus.req_size, bus.req_addr)) begin
                        // Faulting ops never touch the memory.
                        stateNext     = RESP;
                        respValidNext = 1'b1;
                        respRdataNext = 32'b0;
                        respExcNext   = bus.req_write ? 2'b10 : 2'b01;
                    end else begin
                        stateNext      = ACCESS;
                        memEnNext      = 1'b1;
                        memWeNext      = bus.req_write;
                        memAddrNext    = {bus.req_addr[31:2], 2'b00};
                        memByteenNext  = bus.req_write ? laneEnables(bus.req_size, bus.req_addr[1:0]) : 4'b0;
                        memWdataNext   = bus.req_write ? laneData(bus.req_size, bus.req_wdata) : 32'b0;
                        waitCntNext    = 16'b0;
                        opSizeNext     = bus.req_size;
                        opUnsignedNext = bus.req_unsigned;
                        opOffNext      = bus.req_addr[1:0];
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    stateNext     = RESP;
                    memEnNext     = 1'b0;
                    respValidNext = 1'b1;
                    respExcNext   = 2'b00;
                    respRdataNext = memWe ? 32'b0 : extendLoad(opSize, opUnsigned, opOff, bus.mem_rdata);
                end else if (TIMEOUT != 0 && waitCnt == LAST_WAIT) begin
                    stateNext     = RESP;
                    memEnNext     = 1'b0;
                    respValidNext = 1'b1;
                    respExcNext   = 2'b11;
                    respRdataNext = 32'b0;
                end else begin
                    waitCntNext = waitCnt + 16'd1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.stall      = bus.req_valid & ~respValid;
    assign bus.mem_en     = memEn;
    assign bus.mem_we     = memWe;
    assign bus.mem_addr   = memAddr;
    assign bus.mem_byteen = memByteen;
    assign bus.mem_wdata  = memWdata;
    assign bus.resp_valid = respValid;
    assign bus.resp_rdata = respRdata;
    assign bus.resp_exc   = respExc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed ops with literal expectations plus
// randomized loads/stores against a behavioural model of the unit.
module tb_mem_access_unit;

    localparam int TO = 16;

    typedef struct {
        bit        write;
        bit [1:0]  size;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        int        delay;   // mem_en cycle in which ack arrives; 0 = never
    } op_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    mem_access_if bus();

    mem_access_unit #(.ADDR_LIMIT(32'h0000_3000), .TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail = 0;

    // Expectations for the op in flight
    bit        pending = 1'b0;
    bit        inReset = 1'b1;
    bit        eIllegal, eWe;
    bit [31:0] eAddr, eWdata, eRdata;
    bit [3:0]  eByteen;
    bit [1:0]  eExc;
    int        eLat, eEn;
    // Responder configuration
    int        cfgDelay = 0;
    bit [31:0] cfgRdata = 0;
    int        enCnt = 0;
    // Observations
    int        enSeen = 0;
    int        lastLat = 0;
    logic        capWe;
    logic [31:0] capAddr, capWdata, capRdata;
    logic [3:0]  capByteen;
    logic [1:0]  capExc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what one op must produce.
    task automatic model(input op_t op);
        int nb;
        int off;
        bit [31:0] mask, v;
        bit timedOut;
        nb  = (op.size == 2'd0) ? 4 : (op.size == 2'd1) ? 2 : 1;
        off = int'(op.addr[1:0]);
        eIllegal = (op.size == 2'd3) || (op.size == 2'd1 && op.addr[0]) ||
                   (op.size == 2'd0 && op.addr[1:0] != 0) || (op.addr >= 32'h3000);
        timedOut = (op.delay == 0) || (op.delay > TO);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
        eWe     = op.write;
        eAddr   = op.addr & 32'hFFFF_FFFC;
        eByteen = op.write ? 4'(((1 << nb) - 1) << off) : 4'd0;
        if (!op.write)    eWdata = 0;
        else if (nb == 1) eWdata = (op.wdata & 32'hFF) * 32'h0101_0101;
        else if (nb == 2) eWdata = (op.wdata & 32'hFFFF) * 32'h0001_0001;
        else              eWdata = op.wdata;
        v = (op.rdata >> (8 * off)) & mask;
        if (!op.uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        eRdata = (eIllegal || op.write || timedOut) ? 32'd0 : v;
        eExc   = eIllegal ? (op.write ? 2'd2 : 2'd1) : (timedOut ? 2'd3 : 2'd0);
        eLat   = eIllegal ? 1 : (timedOut ? TO + 1 : op.delay + 1);
        eEn    = eIllegal ? 0 : (timedOut ? TO : op.delay);
    endtask

    // Memory model: acks in the configured mem_en cycle, throws stray acks when idle.
    always @(negedge clk) begin
        if (!bus.mem_en) begin
            enCnt = 0;
            bus.mem_ack = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = $urandom;
        end else begin
            enCnt++;
            if (cfgDelay != 0 && enCnt == cfgDelay) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = cfgRdata;
            end else begin
                bus.mem_ack = 1'b0;
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Compare process: checks the bus every cycle against the model expectations.
    always @(negedge clk) begin
        if (!inReset) begin
            check("stall", bus.stall, bus.req_valid & ~bus.resp_valid);
            if (bus.mem_en) begin
                enSeen++;
                check("mem_en_allowed", {31'b0, bus.mem_en}, {31'b0, pending && !eIllegal});
                check("mem_we", bus.mem_we, eWe);
                check("mem_addr", bus.mem_addr, eAddr);
                check("mem_byteen", bus.mem_byteen, eByteen);
                check("mem_wdata", bus.mem_wdata, eWdata);
                capWe = bus.mem_we; capAddr = bus.mem_addr;
                capByteen = bus.mem_byteen; capWdata = bus.mem_wdata;
            end
            if (bus.resp_valid) begin
                check("resp_expected", {31'b0, pending}, 32'd1);
                check("resp_rdata", bus.resp_rdata, eRdata);
                check("resp_exc", bus.resp_exc, eExc);
                capRdata = bus.resp_rdata; capExc = bus.resp_exc;
                pending = 1'b0;
            end
        end
    end

    function automatic op_t mk(input bit w, input bit [1:0] s, input bit u, input bit [31:0] a,
                               input bit [31:0] wd, input bit [31:0] rd, input int d);
        op_t o;
        o.write = w; o.size = s; o.uns = u; o.addr = a; o.wdata = wd; o.rdata = rd; o.delay = d;
        return o;
    endfunction

    // Runs one op; called and returns 1 time unit after a rising edge.
    task automatic runOp(input op_t op);
        bit got;
        model(op);
        cfgDelay = op.delay;
        cfgRdata = op.rdata;
        enSeen = 0;
        pending = 1'b1;
        capWe = 1'bx; capAddr = 'x; capByteen = 'x; capWdata = 'x; capRdata = 'x; capExc = 'x;
        bus.req_valid = 1'b1;
        bus.req_write = op.write;
        bus.req_size = op.size;
        bus.req_unsigned = op.uns;
        bus.req_addr = op.addr;
        bus.req_wdata = op.wdata;
        @(negedge clk);
        check("ready_idle", {31'b0, bus.req_ready}, 32'd1);
        got = 1'b0;
        lastLat = 0;
        for (int lat = 1; lat <= 60 && !got; lat++) begin
            @(posedge clk);
            #1;
            // Busy: the unit must ignore whatever the stage presents now.
            bus.req_write = 1'($urandom);
            bus.req_size = 2'($urandom);
            bus.req_unsigned = 1'($urandom);
            bus.req_addr = $urandom;
            bus.req_wdata = $urandom;
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1'b1;
                lastLat = lat;
            end
        end
        if (!got) begin
            check("resp_arrived", 32'd0, 32'd1);
            pending = 1'b0;
        end else begin
            check("latency", lastLat, eLat);
            check("ready_in_resp", {31'b0, bus.req_ready}, 32'd0);
            check("en_cycles", enSeen, eEn);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        op_t o;
        int r;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 0; bus.req_wdata = 0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_mem_byteen", {28'b0, bus.mem_byteen}, 32'd0);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_exc", {30'b0, bus.resp_exc}, 32'd0);
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        inReset = 1'b0;
        @(posedge clk);
        #1;

        // lw 0x10, ack in the third mem_en cycle
        runOp(mk(0, 2'd0, 0, 32'h10, 0, 32'hDEAD_BEEF, 3));
        check("lw_addr", capAddr, 32'h10);
        check("lw_rdata", capRdata, 32'hDEAD_BEEF);
        check("lw_exc", {30'b0, capExc}, 32'd0);
        check("lw_latency", lastLat, 32'd4);
        // byte/half loads with sign and zero extension
        runOp(mk(0, 2'd2, 0, 32'h13, 0, 32'h80FF_7F01, 1));
        check("lb_rdata", capRdata, 32'hFFFF_FF80);
        check("lb_latency", lastLat, 32'd2);
        runOp(mk(0, 2'd2, 1, 32'h13, 0, 32'h80FF_7F01, 2));
        check("lbu_rdata", capRdata, 32'h0000_0080);
        runOp(mk(0, 2'd1, 0, 32'h12, 0, 32'h80FF_7F01, 1));
        check("lh_rdata", capRdata, 32'hFFFF_80FF);
        // stores
        runOp(mk(1, 2'd2, 0, 32'h21, 32'h1234_56AB, 0, 2));
        check("sb_byteen", {28'b0, capByteen}, 32'b0010);
        check("sb_wdata", capWdata, 32'hABAB_ABAB);
        check("sb_we", {31'b0, capWe}, 32'd1);
        check("sb_rdata", capRdata, 32'd0);
        runOp(mk(1, 2'd1, 0, 32'h22, 32'h1234_56AB, 0, 1));
        check("sh_byteen", {28'b0, capByteen}, 32'b1100);
        check("sh_wdata", capWdata, 32'h56AB_56AB);
        // exceptions
        runOp(mk(0, 2'd0, 0, 32'h06, 0, 0, 1));
        check("lw_misalign_exc", {30'b0, capExc}, 32'd1);
        check("lw_misalign_noen", enSeen, 32'd0);
        runOp(mk(1, 2'd1, 0, 32'h2FFF, 0, 0, 1));
        check("sh_misalign_exc", {30'b0, capExc}, 32'd2);
        runOp(mk(1, 2'd0, 0, 32'h3000, 0, 0, 1));
        check("sw_range_exc", {30'b0, capExc}, 32'd2);
        check("sw_range_noen", enSeen, 32'd0);
        // timeout, then idle cycles with stray acks that must not respond
        runOp(mk(0, 2'd0, 0, 32'h100, 0, 0, 0));
        check("timeout_exc", {30'b0, capExc}, 32'd3);
        check("timeout_en_cycles", enSeen, 32'd16);
        idle(5);

        // reset two cycles into ACCESS
        model(mk(0, 2'd0, 0, 32'h40, 0, 0, 0));
        cfgDelay = 0;
        enSeen = 0;
        pending = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd0; bus.req_addr = 32'h40;
        idle(3);
        bus.req_valid = 1'b0;
        inReset = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pending = 1'b0;
        @(negedge clk);
        check("rstmid_mem_en", {31'b0, bus.mem_en}, 32'd0);
        check("rstmid_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rstmid_req_ready", {31'b0, bus.req_ready}, 32'd1);
        inReset = 1'b0;
        @(posedge clk);
        #1;

        // back-to-back ops (ready low in RESP is checked inside runOp)
        runOp(mk(0, 2'd0, 0, 32'h200, 0, 32'h0BAD_F00D, 1));
        runOp(mk(1, 2'd0, 0, 32'h204, 32'hCAFE_0001, 0, 1));
        check("b2b_we", {31'b0, capWe}, 32'd1);

        // randomized ops
        for (int i = 0; i < 80; i++) begin
            o.write = 1'($urandom);
            r = int'($urandom_range(0, 9));
            o.size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            o.uns = 1'($urandom);
            if ($urandom_range(0, 7) == 0) o.addr = $urandom_range(32'h2FF0, 32'h3010);
            else o.addr = $urandom_range(0, 32'h2FFF);
            if ($urandom_range(0, 3) != 0) begin
                if (o.size == 2'd0) o.addr[1:0] = 2'b00;
                if (o.size == 2'd1) o.addr[0] = 1'b0;
            end
            o.wdata = $urandom;
            o.rdata = $urandom;
            r = int'($urandom_range(0, 9));
            o.delay = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(14, 20)) : int'($urandom_range(1, 4));
            runOp(o);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", nChecks);
        $fatal(1, "watchdog");
    end

endmodule
